// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_pkg                                                         |
// | Purpose  : Shared datapath constants for the ALU shifter family. These     |
// |            values supply the default width of each shifter.                |
// | Contents : DATA_W  - default datapath width in bits                        |
// |            SHAMT_W - shift-amount width for DATA_W                         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package alu_pkg;

   localparam int DATA_W  = 32;
   localparam int SHAMT_W = $clog2(DATA_W);

endpackage : alu_pkg
`default_nettype wire

// File: rtl/shift_left_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : shift_left_stage                                                |
// | Purpose  : One level of the log2 left barrel. It shifts d left by 2^K,     |
// |            zero-filling the vacated LSBs, when sel is high. Otherwise it   |
// |            passes d through unchanged.                                     |
// | Ports    : d   [N-1:0] in  - stage operand                                 |
// |            sel         in  - shift enable (one bit of the shift amount)    |
// |            q   [N-1:0] out - stage result                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module shift_left_stage #(
   parameter int N = alu_pkg::DATA_W,
   parameter int K = 0
) (
   input  logic [N-1:0] d,
   input  logic         sel,
   output logic [N-1:0] q
);

   // K never exceeds log2(N)-1, so the shift is always strictly less than N
   // and the slice below is never empty.
   localparam int c_shift = 2 ** K;

   logic [N-1:0] w_shifted;

   assign w_shifted = {d[N-1-c_shift:0], {c_shift{1'b0}}};
   assign q         = sel ? w_shifted : d;

endmodule : shift_left_stage
`default_nettype wire

// File: rtl/shift_left_logical.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : shift_left_logical                                              |
// | Purpose  : Logical left barrel shifter with two outputs:                   |
// |            - out, a combinational result                                   |
// |            - out_q/valid_q, a registered copy for pipelined consumers      |
// |            The shifter is built as log2(N) cascaded stages. Stage k        |
// |            shifts by 2^k under control of shamt[k].                        |
// | Ports    : clk              in  - rising-edge clock (registered path only) |
// |            rst_n            in  - asynchronous active-low reset            |
// |            in      [N-1:0]  in  - operand                                  |
// |            shamt   [S-1:0]  in  - unsigned shift amount, 0..N-1            |
// |            valid_in         in  - capture qualifier for out_q              |
// |            out     [N-1:0]  out - in << shamt, combinational               |
// |            out_q   [N-1:0]  out - registered result                        |
// |            valid_q          out - out_q was captured on the previous edge  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module shift_left_logical
   import alu_pkg::*;
#(
   parameter int N = DATA_W,
   parameter int S = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] in,
   input  logic [S-1:0] shamt,
   input  logic         valid_in,
   output logic [N-1:0] out,
   output logic [N-1:0] out_q,
   output logic         valid_q
);

   // w_stage[0] is the raw operand. w_stage[k+1] is the output of stage k.
   logic [S:0][N-1:0] w_stage;
   logic [N-1:0]      r_out_q;
   logic              r_valid_q;

   assign w_stage[0] = in;

   generate
      for (genvar k = 0; k < S; k++) begin : g_stage
         shift_left_stage #(
            .N (N),
            .K (k)
         ) u_stage (
            .d   (w_stage[k]),
            .sel (shamt[k]),
            .q   (w_stage[k+1])
         );
      end
   endgenerate

   assign out = w_stage[S];

   // valid_q follows valid_in every cycle. out_q only loads on a valid
   // cycle, so it keeps the last captured result while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_q   <= '0;
         r_valid_q <= 1'b0;
      end else begin
         r_valid_q <= valid_in;
         if (valid_in) begin
            r_out_q <= out;
         end
      end
   end

   assign out_q   = r_out_q;
   assign valid_q = r_valid_q;

endmodule : shift_left_logical
`default_nettype wire

// File: tb/tb_shift_left_logical.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_shift_left_logical                                           |
// | Purpose  : Self-checking bench for shift_left_logical, with a 32-bit and   |
// |            an 8-bit instance. The driver checks the combinational output   |
// |            directly and queues the expected registered result. A monitor  |
// |            pops one entry from that queue for every valid_q.               |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_shift_left_logical;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] in;
   logic [4:0]  shamt;
   logic        valid_in;
   logic [31:0] out;
   logic [31:0] out_q;
   logic        valid_q;

   logic [7:0]  in8;
   logic [2:0]  shamt8;
   logic        valid8;
   logic [7:0]  out8;
   logic [7:0]  out_q8;
   logic        valid_q8;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   shift_left_logical #(.N(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in       (in),
      .shamt    (shamt),
      .valid_in (valid_in),
      .out      (out),
      .out_q    (out_q),
      .valid_q  (valid_q)
   );

   shift_left_logical #(.N(8)) dut8 (
      .clk      (clk),
      .rst_n    (rst_n),
      .in       (in8),
      .shamt    (shamt8),
      .valid_in (valid8),
      .out      (out8),
      .out_q    (out_q8),
      .valid_q  (valid_q8)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Drive one vector at the falling edge, then check the combinational
   // result. When valid, also queue the result expected on out_q.
   task automatic apply(input string nm, input logic [31:0] d, input logic [4:0] sh,
                        input logic v, input logic [31:0] exp);
      @(negedge clk);
      in       = d;
      shamt    = sh;
      valid_in = v;
      if (v && rst_n) exp_q.push_back(exp);
      #1;
      check(nm, out, exp);
   endtask

   // Monitor: every valid_q must match the oldest queued expectation.
   always begin
      @(posedge clk);
      #1;
      if (valid_q) begin
         if (exp_q.size() == 0) begin
            check("spurious_valid_q", out_q, 32'hxxxx_xxxx);
         end else begin
            check("out_q", out_q, exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] d;
      logic [4:0]  sh;
      logic        v;

      // Reset held with clock running and valid_in high.
      rst_n    = 1'b0;
      valid_in = 1'b1;
      in       = 32'hFFFF_FFFF;
      shamt    = 5'd0;
      in8      = 8'h00;
      shamt8   = 3'd0;
      valid8   = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("reset_out_q", out_q, 32'h0);
         check("reset_valid_q", {31'b0, valid_q}, 32'h0);
      end
      @(negedge clk);
      valid_in = 1'b0;
      rst_n    = 1'b1;

      // Directed vectors.
      apply("sh31_in0_zero", 32'h0888_8888, 5'd31, 1'b1, 32'h0000_0000);
      apply("sh31_one",      32'h0000_0001, 5'd31, 1'b1, 32'h8000_0000);
      apply("sh0",           32'h0888_8888, 5'd0,  1'b1, 32'h0888_8888);
      apply("sh1",           32'h0888_8888, 5'd1,  1'b1, 32'h1111_1110);
      apply("sh4",           32'h0888_8888, 5'd4,  1'b1, 32'h8888_8880);
      for (int i = 0; i < 32; i++) begin
         d = 32'hFFFF_FFFF;
         apply("ones_sweep", d, 5'(i), 1'b1, d << i);
      end
      for (int i = 0; i < 32; i++) begin
         apply("zero_sweep", 32'h0, 5'(i), 1'b1, 32'h0);
      end

      // Single capture, then hold with valid_in low.
      apply("a5_sh8", 32'h0000_00A5, 5'd8, 1'b1, 32'h0000_A500);
      @(negedge clk);
      valid_in = 1'b0;
      in       = 32'h1234_5678;
      shamt    = 5'd3;
      @(posedge clk);
      #2;
      check("hold_out_q", out_q, 32'h0000_A500);
      check("hold_valid_q", {31'b0, valid_q}, 32'h0);

      // Asynchronous reset between edges.
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_out_q", out_q, 32'h0);
      check("async_rst_valid_q", {31'b0, valid_q}, 32'h0);
      apply("comb_in_reset", 32'hFFFF_FFFF, 5'd0, 1'b1, 32'hFFFF_FFFF);
      @(posedge clk);
      #1;
      check("rst_no_capture_out_q", out_q, 32'h0);
      check("rst_no_capture_valid_q", {31'b0, valid_q}, 32'h0);
      @(negedge clk);
      valid_in = 1'b0;
      rst_n    = 1'b1;

      // Random vectors against the reference shift.
      for (int i = 0; i < 1000; i++) begin
         d  = $urandom;
         sh = 5'($urandom_range(0, 31));
         v  = ($urandom_range(0, 3) != 0);
         apply("random", d, sh, v, d << sh);
      end

      // Drain the pipeline; every queued result must have been consumed.
      @(negedge clk);
      valid_in = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("drain_empty", 32'(exp_q.size()), 32'h0);

      // 8-bit instance.
      @(negedge clk);
      in8    = 8'h01;
      shamt8 = 3'd7;
      valid8 = 1'b1;
      #1;
      check("n8_sh7", {24'b0, out8}, 32'h80);
      @(posedge clk);
      #1;
      check("n8_out_q", {24'b0, out_q8}, 32'h80);
      check("n8_valid_q", {31'b0, valid_q8}, 32'h1);
      @(negedge clk);
      in8    = 8'hB5;
      shamt8 = 3'd3;
      valid8 = 1'b0;
      #1;
      check("n8_b5_sh3", {24'b0, out8}, 32'hA8);
      @(posedge clk);
      #1;
      check("n8_hold_out_q", {24'b0, out_q8}, 32'h80);
      check("n8_hold_valid_q", {31'b0, valid_q8}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_shift_left_logical
`default_nettype wire

// File: doc/shift_left_logical.md
Name: shift_left_logical

Overview:
- Parameterised logical left barrel shifter for the datapath/ALU.
- `out` is the combinational result of `in << shamt`, with vacated LSBs zero-filled.
- A registered copy, `out_q`, with a valid flag, is provided for pipelined consumers.
- Clocked portion: one clock, asynchronous active-low reset.

Parameters:
- N, 32, data width in bits. Must be a power of two and ≥ 2.
- S, $clog2(N), shift-amount width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock for the registered path.
- rst_n  input  1  asynchronous active-low reset.
- in  input  N  operand to shift.
- shamt  input  S  shift amount, unsigned, 0 to N-1.
- valid_in  input  1  qualifies in/shamt for capture into the output register.
- out  output  N  combinational result, in << shamt.
- out_q  output  N  registered result.
- valid_q  output  1  out_q holds a result captured on the previous valid_in.

Behaviour:
- Arithmetic:
  - out[i] = in[i - shamt] for i ≥ shamt.
  - out[i] = 0 for i < shamt.
  - Bits shifted past the MSB are discarded; no carry or overflow output.
- Combinational path:
  - out depends only on in and shamt. Zero latency.
  - Independent of clk, rst_n and valid_in.
  - Must settle within one simulation delta step after an input change; no latches.
- Structure:
  - Log2 barrel: S cascaded stages.
  - Stage k shifts by 2^k when shamt[k] = 1, otherwise passes through.
  - Stage 0 consumes shamt[0]; the final stage drives out.
  - Using a single behavioural "<<" as the whole design is not accepted; it is a reference model for the bench only.
- Boundaries:
  - shamt = 0: out = in.
  - shamt = N-1: out = {in[0], (N-1) zeros}.
  - in = 0: out = 0 for every shamt.
  - Full S-bit shamt range is legal; no out-of-range case exists.
- Registered path, on posedge clk:
  - If valid_in = 1: out_q <= out and valid_q <= 1.
  - If valid_in = 0: out_q holds its value and valid_q <= 0.
  - Latency is exactly 1 cycle.
- Reset:
  - rst_n = 0 asynchronously forces out_q = 0 and valid_q = 0, independent of clk.
  - Reset asserted mid-stream discards the pending result.
  - First capture occurs on the first posedge with rst_n = 1 and valid_in = 1.
  - out (combinational) is unaffected by reset.
- Reset values: out_q = 0, valid_q = 0. out has no reset value; it is combinational.
- Simultaneous events: a reset release coinciding with a clock edge is not a capture edge. Capture requires rst_n already high at that edge.

Decomposition:
- Shared package, alu_pkg:
  - Constant DATA_W = 32.
  - Constant SHAMT_W = $clog2(DATA_W).
  - Used as parameter defaults by this block and by its sibling shifters.
- Sub-module shift_left_stage, parameters N and K:
  - Inputs: N-bit d, 1-bit sel.
  - Output: q = sel ? {d[N-1-2^K:0], 2^K zeros} : d.
  - Instantiated S times via generate.
- Top level: stage chain plus the output register.

Test Plan:
- in=32'h0888_8888, shamt=31 -> out=32'h0000_0000 (in[0]=0); in=32'h0000_0001, shamt=31 -> out=32'h8000_0000.
- in=32'h0888_8888, shamt=0 -> out=32'h0888_8888; shamt=1 -> out=32'h1111_1110; shamt=4 -> out=32'h8888_8880.
- in=32'hFFFF_FFFF, sweep shamt 0..31 -> out=32'hFFFF_FFFF << shamt each step; also in=0 across all shamt -> out=0.
- rst_n=0 with clk toggling and valid_in=1 -> out_q=0, valid_q=0; assert rst_n low between edges -> out_q clears immediately without an edge.
- rst_n=1, valid_in=1, in=32'h0000_00A5, shamt=8 at edge 1 -> after edge 1: out_q=32'h0000_A500, valid_q=1; valid_in=0 at edge 2 -> out_q holds 32'h0000_A500, valid_q=0.
- Random: 1000 random in/shamt pairs against a behavioural "<<" model for both out and 1-cycle-delayed out_q; also rerun with N=8, shamt=7, in=8'h01 -> out=8'h80.
